pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of period and high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 65535: cycles without a rising edge before stuck detection; legal range 16..2^CNT_W-1.
REQ-003 io_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 io_resetn  input  1  synchronous, active-low reset, sampled on io_clk rising edge.
REQ-005 pwm_in  input  1  asynchronous PWM waveform to be measured.
REQ-006 period  output  CNT_W  cycles between the last two rising edges.
REQ-007 high_time  output  CNT_W  cycles pwm_in was high within that period.
REQ-008 duty  output  8  floor(high_time*256/period); same encoding as the team's pwm duty input.
REQ-009 valid  output  1  one-cycle pulse when period/high_time/duty (or stuck status) update.
REQ-010 stuck  output  1  high while no rising edge seen for TIMEOUT cycles.
REQ-011 overrun  output  1  one-cycle pulse when a measurement is dropped.

Function
REQ-012 pwm_in shall pass through a 2-flop synchronizer, then a third register for edge detection; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-013 Cycle of a rise/fall event is the cycle in which rise/fall is true; all timing below is relative to it.
REQ-014 FSM states: WAIT_RISE, MEASURE, DIVIDE; reset state WAIT_RISE.
REQ-015 WAIT_RISE: on rise -> MEASURE, period counter and high counter load 1; no output update.
REQ-016 MEASURE: period counter increments every cycle; high counter increments while s2=1 and no fall seen since the last rise; both saturate at 2^CNT_W-1.
REQ-017 MEASURE, rise at cycle T: latch period counter into period_l and high counter into high_l, reload counters to 1, go DIVIDE; rise events P cycles apart yield period_l = P.
REQ-018 DIVIDE: restoring divider, 8 iterations (one per cycle, T+1..T+8) of high_l*256/period_l; high_l < period_l guarantees quotient <= 255.
REQ-019 At T+9: period, high_time, duty update together, valid pulses for one cycle, stuck cleared, state -> MEASURE; counters keep running during DIVIDE.
REQ-020 Rise during DIVIDE (period < 9): discard in-progress division, pulse overrun, latch new values, restart 8 iterations; outputs unchanged until a division completes.
REQ-021 Timeout: if period counter reaches TIMEOUT in MEASURE or WAIT_RISE (WAIT_RISE counts from reset/stuck entry): stuck=1, duty=255 if s2=1 else 0, period and high_time = 0, valid pulses once, state -> WAIT_RISE; no repeated valid while stuck.
REQ-022 stuck stays 1 until the next completed measurement (REQ-019).
REQ-023 Rise and timeout in the same cycle: rise wins.
REQ-024 First rise after reset or stuck gives no valid; first valid requires two rises.

Reset
REQ-025 While io_resetn=0 at a clock edge: period=0, high_time=0, duty=0, valid=0, stuck=0, overrun=0, synchronizer flops=0, counters=0, state WAIT_RISE.
REQ-026 Reset asserted mid-MEASURE or mid-DIVIDE aborts the operation with no valid or overrun pulse.

Verification
REQ-027 High 100 / low 156 cycles, repeated -> from second rise onward valid every 256 cycles with period=256, high_time=100, duty=100, valid exactly 9 cycles after each rise event.
REQ-028 High 200 / low 340 (50 kHz at 27 MHz) -> period=540, high_time=200, duty=94.
REQ-029 Steady waveform then pwm_in held 1 -> TIMEOUT cycles after the last rise event: stuck=1, duty=255, period=0, single valid; held 0 -> duty=0; next two rises clear stuck with a normal valid.
REQ-030 Period 6 (high 3 / low 3) -> overrun pulses on every rise after the second, no valid.
REQ-031 Reset pulsed during DIVIDE -> all outputs 0 next cycle, no valid; normal measurement resumes after two subsequent rises.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM input capture: measures period, high time and 8-bit duty of an asynchronous
// PWM waveform, and reports a stuck input when rising edges stop arriving.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             io_clk,
  input  logic             io_resetn,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [7:0]       duty,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEASURE   = 2'd1,
    DIVIDE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TIMEOUT);

  logic             sync1_r;
  logic             sync2_r;
  logic             sync3_r;
  logic             rise_s;
  logic             fall_s;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [CNT_W-1:0] per_cnt_r;
  logic [CNT_W-1:0] high_cnt_r;
  logic             fall_seen_r;

  logic [CNT_W-1:0] period_l_r;
  logic [CNT_W-1:0] high_l_r;
  logic [CNT_W-1:0] rem_r;
  logic [6:0]       quo_r;
  logic [2:0]       iter_r;

  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_time_r;
  logic [7:0]       duty_r;
  logic             valid_r;
  logic             stuck_r;
  logic             overrun_r;

  logic             tmo_s;
  logic             div_done_s;
  logic             div_overrun_s;

  logic [CNT_W:0]   shift_s;
  logic [CNT_W:0]   diff_s;
  logic             qbit_s;
  logic [CNT_W-1:0] rem_nxt_s;
  logic [7:0]       quo_nxt_s;

  // Two-flop synchronizer plus a third stage for edge detection
  always_ff @(posedge io_clk) begin
    if (!io_resetn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= pwm_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Edge and event decode; a rise always takes priority over a timeout
  always_comb begin
    rise_s        = sync2_r & ~sync3_r;
    fall_s        = ~sync2_r & sync3_r;
    tmo_s         = ((state_r == WAIT_RISE) || (state_r == MEASURE)) &&
                    !rise_s && (per_cnt_r == CNT_TMO);
    div_overrun_s = (state_r == DIVIDE) && rise_s;
    div_done_s    = (state_r == DIVIDE) && !rise_s && (iter_r == 3'd7);
  end

  // FSM state register
  always_ff @(posedge io_clk) begin
    if (!io_resetn) begin
      state_r <= WAIT_RISE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_RISE: begin
        if (rise_s) begin
          state_nxt_s = MEASURE;
        end else begin
          state_nxt_s = WAIT_RISE;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          state_nxt_s = DIVIDE;
        end else if (tmo_s) begin
          state_nxt_s = WAIT_RISE;
        end else begin
          state_nxt_s = MEASURE;
        end
      end
      DIVIDE: begin
        if (rise_s) begin
          state_nxt_s = DIVIDE;
        end else if (div_done_s) begin
          state_nxt_s = MEASURE;
        end else begin
          state_nxt_s = DIVIDE;
        end
      end
      default: begin
        state_nxt_s = WAIT_RISE;
      end
    endcase
  end

  // Period and high-time counters; both keep running through DIVIDE.
  // In WAIT_RISE only the period counter runs, so it doubles as the stuck timer.
  always_ff @(posedge io_clk) begin
    if (!io_resetn) begin
      per_cnt_r   <= CNT_ZERO;
      high_cnt_r  <= CNT_ZERO;
      fall_seen_r <= 1'b0;
    end else if (rise_s) begin
      per_cnt_r   <= CNT_ONE;
      high_cnt_r  <= CNT_ONE;
      fall_seen_r <= 1'b0;
    end else if (tmo_s) begin
      per_cnt_r   <= CNT_ZERO;
      high_cnt_r  <= CNT_ZERO;
      fall_seen_r <= 1'b0;
    end else begin
      if (per_cnt_r != CNT_MAX) begin
        per_cnt_r <= per_cnt_r + CNT_ONE;
      end
      if (state_r == WAIT_RISE) begin
        high_cnt_r <= CNT_ZERO;
      end else if (sync2_r && !fall_seen_r && (high_cnt_r != CNT_MAX)) begin
        high_cnt_r <= high_cnt_r + CNT_ONE;
      end
      if (fall_s) begin
        fall_seen_r <= 1'b1;
      end
    end
  end

  // One restoring-division step; high_l < period_l keeps every remainder below the divisor
  always_comb begin
    shift_s   = {rem_r, 1'b0};
    diff_s    = shift_s - {1'b0, period_l_r};
    qbit_s    = ~diff_s[CNT_W];
    rem_nxt_s = qbit_s ? diff_s[CNT_W-1:0] : shift_s[CNT_W-1:0];
    quo_nxt_s = {quo_r, qbit_s};
  end

  // Latch a finished period on each rise and iterate the divider during DIVIDE
  always_ff @(posedge io_clk) begin
    if (!io_resetn) begin
      period_l_r <= CNT_ZERO;
      high_l_r   <= CNT_ZERO;
      rem_r      <= CNT_ZERO;
      quo_r      <= 7'd0;
      iter_r     <= 3'd0;
    end else if (rise_s) begin
      period_l_r <= per_cnt_r;
      high_l_r   <= high_cnt_r;
      rem_r      <= high_cnt_r;
      quo_r      <= 7'd0;
      iter_r     <= 3'd0;
    end else if (state_r == DIVIDE) begin
      rem_r      <= rem_nxt_s;
      quo_r      <= quo_nxt_s[6:0];
      iter_r     <= iter_r + 3'd1;
    end
  end

  // Registered result outputs; a repeated timeout while already stuck is silent
  always_ff @(posedge io_clk) begin
    if (!io_resetn) begin
      period_r    <= CNT_ZERO;
      high_time_r <= CNT_ZERO;
      duty_r      <= 8'd0;
      valid_r     <= 1'b0;
      stuck_r     <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      valid_r   <= 1'b0;
      overrun_r <= div_overrun_s;
      if (div_done_s) begin
        period_r    <= period_l_r;
        high_time_r <= high_l_r;
        duty_r      <= quo_nxt_s;
        valid_r     <= 1'b1;
        stuck_r     <= 1'b0;
      end else if (tmo_s && !stuck_r) begin
        period_r    <= CNT_ZERO;
        high_time_r <= CNT_ZERO;
        duty_r      <= sync2_r ? 8'd255 : 8'd0;
        valid_r     <= 1'b1;
        stuck_r     <= 1'b1;
      end
    end
  end

  assign period    = period_r;
  assign high_time = high_time_r;
  assign duty      = duty_r;
  assign valid     = valid_r;
  assign stuck     = stuck_r;
  assign overrun   = overrun_r;

endmodule
